// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Purpose  : 640x480 @ 60 Hz VGA timing generator. Divides clk down to the
//            pixel rate and runs the horizontal/vertical scan counters. Drives
//            active-low hsync/vsync, plus pixel_x, pixel_y and video_on for
//            the drawing logic. All outputs are registered and change on the
//            same clk edge.
// Ports    : clk          system clock (only clock)
//            rst          synchronous reset, active-high
//            p_tick       one-clk pixel-enable pulse
//            pixel_x      horizontal scan count, 0..H_TOTAL-1
//            pixel_y      vertical scan count, 0..V_TOTAL-1
//            video_on     high inside the visible area
//            hsync        horizontal sync, active-low
//            vsync        vertical sync, active-low
//            frame_start  one-clk pulse when the scan enters (0,0)
//            frame_cnt    8-bit frame counter (only with VGA_SYNC_FRAME_CNT_EN)
// Options  : define VGA_SYNC_FRAME_CNT_EN to add the frame_cnt port/register
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int DIV       = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int c_h_total = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  // Keep the divider at least one bit wide so DIV=1 still elaborates.
  localparam int c_div_w   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [c_div_w-1:0] c_div_max  = c_div_w'(DIV - 1);
  localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
  localparam logic [9:0]         c_h_max    = 10'(c_h_total - 1);
  localparam logic [9:0]         c_v_max    = 10'(c_v_total - 1);
  localparam logic [9:0]         c_h_disp   = 10'(H_DISPLAY);
  localparam logic [9:0]         c_v_disp   = 10'(V_DISPLAY);
  localparam logic [9:0]         c_hs_start = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]         c_hs_end   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]         c_vs_start = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]         c_vs_end   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [c_div_w-1:0] div_q, div_d;
  logic               p_tick_q, p_tick_d;
  logic [9:0]         h_q, h_d;
  logic [9:0]         v_q, v_d;
  logic               video_on_q, video_on_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               frame_start_q, frame_start_d;
  logic               h_wrap, v_wrap;

  always_comb begin
    div_d         = (div_q == c_div_max) ? '0 : div_q + c_div_one;
    // p_tick is high in exactly the clk where div_cnt sits at DIV-1.
    p_tick_d      = (div_d == c_div_max);

    // ">=" rather than "==" so any out-of-range count falls back to 0.
    h_wrap        = (h_q >= c_h_max);
    v_wrap        = (v_q >= c_v_max);

    h_d           = h_q;
    v_d           = v_q;
    if (p_tick_q) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = v_wrap ? 10'd0 : v_q + 10'd1;
      end
    end

    // Decoded from the next-state counts so they line up with pixel_x/y.
    hsync_d       = !((h_d >= c_hs_start) && (h_d <= c_hs_end));
    vsync_d       = !((v_d >= c_vs_start) && (v_d <= c_vs_end));
    video_on_d    = (h_d < c_h_disp) && (v_d < c_v_disp);
    frame_start_d = p_tick_q && h_wrap && v_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      p_tick_q      <= 1'b0;
      h_q           <= c_h_max;
      v_q           <= c_v_max;
      video_on_q    <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      p_tick_q      <= p_tick_d;
      h_q           <= h_d;
      v_q           <= v_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 8'd0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign p_tick      = p_tick_q;
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Purpose  : Self-checking bench for vga_sync_gen. Four instances:
//            A - default 640x480 timing, DIV=4 (reset release, line timing)
//            B - default timing, DIV=1 (continuous p_tick, 800-clk lines)
//            C - scaled 32x20 raster, DIV=2 (frame timing, mid-frame reset)
//            D - tiny 8x4 raster, DIV=1 (257 frames, frame_cnt wrap)
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;

  logic       a_tick, a_von, a_hs, a_vs, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_von, b_hs, b_vs, b_fs;
  logic [9:0] b_x, b_y;
  logic       c_tick, c_von, c_hs, c_vs, c_fs;
  logic [9:0] c_x, c_y;
  logic       d_tick, d_von, d_hs, d_vs, d_fs;
  logic [9:0] d_x, d_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] a_fc, b_fc, c_fc, d_fc;
`endif

  vga_sync_gen #(.DIV(4)) u_a (
    .clk(clk), .rst(rst_a), .p_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
    .video_on(a_von), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  vga_sync_gen #(.DIV(1)) u_b (
    .clk(clk), .rst(rst_b), .p_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_von), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_cnt(b_fc)
`endif
  );

  // 32 x 20 raster: hsync low on x 20..27, vsync low on y 15..16.
  vga_sync_gen #(
    .DIV(2), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_DISPLAY(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(3)
  ) u_c (
    .clk(clk), .rst(rst_c), .p_tick(c_tick), .pixel_x(c_x), .pixel_y(c_y),
    .video_on(c_von), .hsync(c_hs), .vsync(c_vs), .frame_start(c_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_cnt(c_fc)
`endif
  );

  // 8 x 4 raster, 32 clks per frame.
  vga_sync_gen #(
    .DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(0)
  ) u_d (
    .clk(clk), .rst(rst_d), .p_tick(d_tick), .pixel_x(d_x), .pixel_y(d_y),
    .video_on(d_von), .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL sb_empty: observed %0d with no expected entry", obs);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    int n, i, last, per, cnt, lowc, bad1, bad2, bad3, bad4, prev_x;
    int fall_x, rise_x, vfall_x, y_after, line_len, found;
    logic prev_h, prev_v, sync_ok;

    // =========== A: reset release, DIV=4 ===========
    repeat (3) @(posedge clk);
    @(negedge clk);
    push_exp("a_rst_x", 799);  push_exp("a_rst_y", 524);
    push_exp("a_rst_von", 0);  push_exp("a_rst_hs", 1);
    push_exp("a_rst_vs", 1);   push_exp("a_rst_tick", 0);
    push_exp("a_rst_fs", 0);
    pop_cmp(32'(a_x));   pop_cmp(32'(a_y));  pop_cmp(32'(a_von));
    pop_cmp(32'(a_hs));  pop_cmp(32'(a_vs)); pop_cmp(32'(a_tick));
    pop_cmp(32'(a_fs));
`ifdef VGA_SYNC_FRAME_CNT_EN
    push_exp("a_rst_fc", 0);
    pop_cmp(32'(a_fc));
`endif

    rst_a = 1'b0;
    // First p_tick after three edges: the 4th clk period with rst low.
    push_exp("a_first_tick_edge", 3);
    n = 0; sync_ok = 1'b1;
    while (n < 20) begin
      @(negedge clk); n++;
      if (!a_hs || !a_vs) sync_ok = 1'b0;
      if (a_tick) break;
    end
    pop_cmp(n);

    push_exp("a_start_x", 0);   push_exp("a_start_y", 0);
    push_exp("a_start_von", 1); push_exp("a_start_fs", 1);
    push_exp("a_start_tick", 0); push_exp("a_start_hs", 1);
    push_exp("a_start_vs", 1);  push_exp("a_sync_idle", 1);
    @(negedge clk);
    pop_cmp(32'(a_x));    pop_cmp(32'(a_y));  pop_cmp(32'(a_von));
    pop_cmp(32'(a_fs));   pop_cmp(32'(a_tick));
    pop_cmp(32'(a_hs));   pop_cmp(32'(a_vs)); pop_cmp(32'(sync_ok));

    // =========== A: one line ===========
    push_exp("a_hs_fall_x", 656); push_exp("a_hs_rise_x", 752);
    push_exp("a_hs_low_clks", 384); push_exp("a_von_fall_x", 640);
    push_exp("a_line_clks", 3200); push_exp("a_y_after_wrap", 1);
    fall_x = -1; rise_x = -1; vfall_x = -1; y_after = -1; line_len = -1;
    lowc = 0; prev_h = a_hs; prev_v = a_von; prev_x = 32'(a_x);
    for (int k = 1; k <= 3300; k++) begin
      @(negedge clk);
      if (prev_h && !a_hs) fall_x = 32'(a_x);
      if (!prev_h && a_hs) rise_x = 32'(a_x);
      if (!a_hs) lowc++;
      if (prev_v && !a_von) vfall_x = 32'(a_x);
      if (prev_x == 799 && a_x == 10'd0) begin
        line_len = k; y_after = 32'(a_y);
        break;
      end
      prev_h = a_hs; prev_v = a_von; prev_x = 32'(a_x);
    end
    pop_cmp(fall_x);  pop_cmp(rise_x); pop_cmp(lowc);
    pop_cmp(vfall_x); pop_cmp(line_len); pop_cmp(y_after);
    rst_a = 1'b1;

    // =========== B: DIV=1 ===========
    push_exp("b_rst_x", 799); push_exp("b_rst_y", 524);
    push_exp("b_rst_hs", 1);  push_exp("b_rst_vs", 1);
    push_exp("b_rst_von", 0); push_exp("b_rst_fs", 0);
    pop_cmp(32'(b_x));  pop_cmp(32'(b_y));  pop_cmp(32'(b_hs));
    pop_cmp(32'(b_vs)); pop_cmp(32'(b_von)); pop_cmp(32'(b_fs));
    rst_b = 1'b0;
    push_exp("b_first_tick_edge", 1);
    n = 0;
    while (n < 10) begin
      @(negedge clk); n++;
      if (b_tick) break;
    end
    pop_cmp(n);
    push_exp("b_tick_gaps", 0); push_exp("b_x_skips", 0);
    push_exp("b_line_clks", 800);
    bad1 = 0; bad2 = 0; last = -1; per = -1; prev_x = 32'(b_x);
    for (int k = 1; k <= 1700; k++) begin
      @(negedge clk);
      if (!b_tick) bad1++;
      if (32'(b_x) != (prev_x + 1) % 800) bad2++;
      if (b_x == 10'd0) begin
        if (last >= 0) per = k - last;
        last = k;
      end
      prev_x = 32'(b_x);
    end
    pop_cmp(bad1); pop_cmp(bad2); pop_cmp(per);
    rst_b = 1'b1;

    // =========== C: frame timing on the scaled raster ===========
    rst_c = 1'b0;
    push_exp("c_first_frame_edge", 2);
    n = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (c_fs) break;
    end
    pop_cmp(n);
    push_exp("c_hs_decode_err", 0); push_exp("c_vs_decode_err", 0);
    push_exp("c_von_decode_err", 0); push_exp("c_fs_pos_err", 0);
    push_exp("c_vs_low_clks", 128); push_exp("c_frame_clks", 1280);
    push_exp("c_frame_pulses", 2);
    bad1 = 0; bad2 = 0; bad3 = 0; bad4 = 0; lowc = 0; last = 0; per = -1; cnt = 0;
    for (int k = 1; k <= 2560; k++) begin
      @(negedge clk);
      if (c_hs !== !(c_x >= 10'd20 && c_x <= 10'd27)) bad1++;
      if (c_vs !== !(c_y >= 10'd15 && c_y <= 10'd16)) bad2++;
      if (c_von !== (c_x < 10'd16 && c_y < 10'd12)) bad3++;
      if (k <= 1280 && !c_vs) lowc++;
      if (c_fs) begin
        if (c_x != 10'd0 || c_y != 10'd0) bad4++;
        per = k - last; last = k; cnt++;
      end
    end
    pop_cmp(bad1); pop_cmp(bad2); pop_cmp(bad3); pop_cmp(bad4);
    pop_cmp(lowc); pop_cmp(per); pop_cmp(cnt);

    // =========== C: reset in the middle of a vsync/hsync pulse ===========
    push_exp("c_found_sync_point", 1); push_exp("c_vs_before_rst", 0);
    found = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (c_y == 10'd15 && !c_hs) begin
        found = 1;
        break;
      end
    end
    pop_cmp(found); pop_cmp(32'(c_vs));
    rst_c = 1'b1;
    push_exp("c_mrst_vs", 1); push_exp("c_mrst_hs", 1);
    push_exp("c_mrst_x", 31); push_exp("c_mrst_y", 19);
    push_exp("c_mrst_von", 0); push_exp("c_mrst_tick", 0);
    @(negedge clk);
    pop_cmp(32'(c_vs)); pop_cmp(32'(c_hs)); pop_cmp(32'(c_x));
    pop_cmp(32'(c_y));  pop_cmp(32'(c_von)); pop_cmp(32'(c_tick));
    rst_c = 1'b0;
    push_exp("c_restart_edge", 2); push_exp("c_restart_x", 0);
    push_exp("c_restart_y", 0); push_exp("c_restart_von", 1);
    n = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (c_fs) break;
    end
    pop_cmp(n); pop_cmp(32'(c_x)); pop_cmp(32'(c_y)); pop_cmp(32'(c_von));
    rst_c = 1'b1;

    // =========== D: 257 frames ===========
    push_exp("d_rst_x", 7); push_exp("d_rst_y", 3);
    push_exp("d_rst_von", 0); push_exp("d_rst_tick", 0);
    pop_cmp(32'(d_x)); pop_cmp(32'(d_y)); pop_cmp(32'(d_von)); pop_cmp(32'(d_tick));
`ifdef VGA_SYNC_FRAME_CNT_EN
    push_exp("d_rst_fc", 0);
    pop_cmp(32'(d_fc));
`endif
    rst_d = 1'b0;
    push_exp("d_frame_pulses", 257); push_exp("d_frame_clks", 32);
    push_exp("d_sync_seen", 1);
    cnt = 0; last = -1; per = -1; bad1 = 0;
    for (int k = 1; k <= 257 * 32 + 200; k++) begin
      @(negedge clk);
      if (!d_hs && !d_vs) bad1 = 1;
      if (d_fs) begin
        if (last >= 0) per = k - last;
        last = k; cnt++;
        if (cnt == 257) break;
      end
    end
    pop_cmp(cnt); pop_cmp(per); pop_cmp(bad1);
`ifdef VGA_SYNC_FRAME_CNT_EN
    push_exp("d_frame_cnt_wrap", 1);
    pop_cmp(32'(d_fc));
`endif
    rst_d = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator for the 640x480 @ 60 Hz VGA output path. Divides the system clock down to the pixel rate, runs the horizontal and vertical scan counters, and drives `hsync`/`vsync` to the connector. It also supplies `pixel_x`, `pixel_y` and `video_on` to the frame/character drawing logic, whose RGB outputs are combinational in those signals.

## Interface
- `DIV`, 4: system clocks per pixel; 100 MHz / 4 = 25 MHz. Must be ≥ 1.
- `H_DISPLAY`, 640; `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48. H_TOTAL = 800.
- `V_DISPLAY`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33. V_TOTAL = 525.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  synchronous reset, active-high.
- `p_tick`  out  1  one-`clk` pixel-enable pulse.
- `pixel_x`  out  10  horizontal scan count, 0..H_TOTAL-1.
- `pixel_y`  out  10  vertical scan count, 0..V_TOTAL-1.
- `video_on`  out  1  high inside the visible 640x480 area.
- `hsync`  out  1  horizontal sync, active-low.
- `vsync`  out  1  vertical sync, active-low.
- `frame_start`  out  1  one-`clk` pulse when the scan enters (0,0).
- `frame_cnt`  out  8  frame counter; present only with `VGA_SYNC_FRAME_CNT_EN`.

## Operation
- **Divider:** `div_cnt` counts 0..DIV-1 and wraps. `p_tick` is registered and is high for exactly the one `clk` in which `div_cnt` = DIV-1. With DIV=1, `p_tick` is constantly high after reset.
- **Horizontal counter:** `h_cnt` advances on each `clk` edge where `p_tick` is sampled high. At H_TOTAL-1 it wraps to 0.
- **Vertical counter:** `v_cnt` increments only when `h_cnt` wraps. At V_TOTAL-1 it wraps to 0.
- **Scan outputs:** `pixel_x` = `h_cnt` and `pixel_y` = `v_cnt`, both registered.
- **Sync:** `hsync` = 0 iff `h_cnt` is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. [656,751]. `vsync` = 0 iff `v_cnt` is in [490,491].
- **Blanking:** `video_on` = (`h_cnt` < H_DISPLAY) && (`v_cnt` < V_DISPLAY).
- **Alignment:** `hsync`, `vsync` and `video_on` are registered from the next-state counter values, so all outputs change on the same edge with no skew and no combinational glitches.
- **Frame start:** `frame_start` is high for one `clk`, on the edge where the counters become (0,0).
- **Reset values:** `div_cnt`=0, `p_tick`=0, `h_cnt`=799, `v_cnt`=524 (so `pixel_x`=799, `pixel_y`=524), `video_on`=0, `hsync`=1, `vsync`=1, `frame_start`=0, `frame_cnt`=0.
- **After reset:** the first counter advance wraps the scan to (0,0), so the first frame is complete from pixel (0,0).
- **Reset mid-frame:** returns all state to the reset values on the next edge. No partial sync pulse is extended; `hsync`/`vsync` go to 1 immediately.
- **Counter widths:** 10 bits, with no out-of-range values reachable. Any out-of-range value (e.g. from a parameter misuse) wraps to 0 on the next advance.

## Timing
- Counters update one `clk` after the `p_tick` pulse and then hold for DIV clks. Downstream logic sees each pixel for DIV clks.
- First `p_tick` is high in the DIV-th cycle after `rst` falls.
- Pixel (0,0), `frame_start`=1 and `video_on`=1 all appear on the following edge.
- Line period: 800 × DIV clks = 3200 clks.
- Frame period: 525 × 3200 = 1,680,000 clks.
- `hsync` low: 96 × DIV = 384 clks per line.
- `vsync` low: 2 lines = 6400 clks per frame.
- `video_on` high: 640 × DIV clks on each of lines 0..479.

## Configuration
- `VGA_SYNC_FRAME_CNT_EN` defined: `frame_cnt` port and register exist. The counter increments on the same edge as `frame_start`, wraps 255→0, and resets to 0.
- `VGA_SYNC_FRAME_CNT_EN` undefined: the port and register are absent. All other behaviour is identical.

## Test plan
- **Reset release:** DIV=4; hold `rst` 3 clks, release.
  - `p_tick` first high at cycle 4.
  - Next edge: `pixel_x`=0, `pixel_y`=0, `video_on`=1, `frame_start`=1.
  - `hsync`=`vsync`=1 throughout.
- **Line timing:** run one line.
  - `hsync` falls when `pixel_x`=656 and rises when `pixel_x`=752; low for exactly 384 clks.
  - `video_on` falls when `pixel_x`=640.
  - At `pixel_x` 799→0, `pixel_y` increments.
- **Frame timing:** run one full frame.
  - `vsync` low only for `pixel_y` 490..491, i.e. 6400 clks.
  - `video_on`=0 for all `pixel_y` ≥ 480.
  - `frame_start` pulses recur exactly 1,680,000 clks apart.
- **Mid-frame reset:** assert `rst` for 1 clk while `pixel_y`=490 and `hsync`=0.
  - Next edge: `vsync`=1, `hsync`=1, `pixel_x`=799, `pixel_y`=524, `video_on`=0.
  - Normal restart follows.
- **DIV=1:** `p_tick` stays high continuously; `pixel_x` increments every clk; line period = 800 clks.
- **`VGA_SYNC_FRAME_CNT_EN` defined:** after 257 `frame_start` pulses, `frame_cnt`=1 (wrapped through 255→0).
